gate_sweep_checker: RTL and testbench



---
 rtl/gate_sweep_if.sv | 20 ++
 rtl/gate_sweep_checker.sv | 79 +++++++
 tb/tb_gate_sweep_checker.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_if.sv
// gate_sweep_if: start/DUT-sample inputs and sweep result bundle for gate_sweep_checker.
interface gate_sweep_if #(
    parameter int N     = 3,
    parameter int ERR_W = 8
);
    logic             start;
    logic             dut_y;
    logic [N-1:0]     vec;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [N-1:0]     fail_vec;
    logic             fail_got;
    logic [ERR_W-1:0] err_count;
    modport master (output start, dut_y,
                    input  vec, busy, done, pass, fail, fail_vec, fail_got, err_count);
    modport slave  (input  start, dut_y,
                    output vec, busy, done, pass, fail, fail_vec, fail_got, err_count);
endinterface

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: walks every N-bit vector into a reduction gate and checks its output 4-state strictly.
module gate_sweep_checker #(
    parameter int N            = 3,
    parameter int FUNC         = 0,
    parameter int SETTLE       = 1,
    parameter int STOP_ON_FAIL = 1,
    parameter int ERR_W        = 8
) (
    input logic        clk,
    input logic        rst_,
    gate_sweep_if.slave sw
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [N-1:0]     vec_q, vec_d, fvec_q, fvec_d;
    logic             fgot_q, fgot_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             exp_y, mis;
    assign exp_y = FUNC == 0 ? ~|vec_q : FUNC == 1 ? |vec_q : FUNC == 2 ? ~&vec_q : &vec_q;
    // X or Z on the DUT output must count as a failure
    assign mis = sw.dut_y !== exp_y;
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        fvec_d  = fvec_q;
        fgot_d  = fgot_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (state_q != RUN) begin
            if (sw.start) begin
                state_d = RUN;
                vec_d   = '0;
                fvec_d  = '0;
                fgot_d  = 1'b0;
                err_d   = '0;
                cnt_d   = 8'(SETTLE);
            end
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = 8'(SETTLE);
            if (mis) begin
                err_d = &err_q ? err_q : err_q + 1'b1;
                if (err_q == '0) begin
                    fvec_d = vec_q;
                    fgot_d = sw.dut_y;
                end
            end
            if (&vec_q || (mis && STOP_ON_FAIL != 0)) state_d = DONE;
            else vec_d = vec_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= IDLE;
            vec_q   <= '0;
            fvec_q  <= '0;
            fgot_q  <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            fvec_q  <= fvec_d;
            fgot_q  <= fgot_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    assign sw.vec       = vec_q;
    assign sw.busy      = state_q == RUN;
    assign sw.done      = state_q == DONE;
    assign sw.pass      = state_q == DONE && err_q == '0;
    assign sw.fail      = state_q == DONE && err_q != '0;
    assign sw.fail_vec  = fvec_q;
    assign sw.fail_got  = fgot_q;
    assign sw.err_count = err_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: three checker configurations driven by table-based gate models, scored against a sweep model.
module tb_gate_sweep_checker;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    int nn[3] = '{3, 3, 4};
    int fn[3] = '{0, 1, 3};
    int st[3] = '{1, 1, 0};
    int sp[3] = '{1, 0, 0};
    int ew[3] = '{8, 8, 2};
    logic        start_r[3];
    logic [15:0] tab_r[3];
    logic [15:0] vec_w[3], fv_w[3];
    logic [7:0]  err_w[3];
    logic        busy_w[3], done_w[3], pass_w[3], fail_w[3], fg_w[3];
    int errors = 0;
    int checks = 0;

    gate_sweep_if #(.N(3), .ERR_W(8)) ia ();
    gate_sweep_if #(.N(3), .ERR_W(8)) ib ();
    gate_sweep_if #(.N(4), .ERR_W(2)) ic ();
    gate_sweep_checker #(.N(3), .FUNC(0), .SETTLE(1), .STOP_ON_FAIL(1), .ERR_W(8)) ua (.clk(clk), .rst_(rst_), .sw(ia));
    gate_sweep_checker #(.N(3), .FUNC(1), .SETTLE(1), .STOP_ON_FAIL(0), .ERR_W(8)) ub (.clk(clk), .rst_(rst_), .sw(ib));
    gate_sweep_checker #(.N(4), .FUNC(3), .SETTLE(0), .STOP_ON_FAIL(0), .ERR_W(2)) uc (.clk(clk), .rst_(rst_), .sw(ic));

    assign ia.start = start_r[0];
    assign ia.dut_y = tab_r[0][ia.vec];
    assign vec_w[0] = 16'(ia.vec);
    assign fv_w[0] = 16'(ia.fail_vec);
    assign err_w[0] = 8'(ia.err_count);
    assign busy_w[0] = ia.busy;
    assign done_w[0] = ia.done;
    assign pass_w[0] = ia.pass;
    assign fail_w[0] = ia.fail;
    assign fg_w[0] = ia.fail_got;
    assign ib.start = start_r[1];
    assign ib.dut_y = tab_r[1][ib.vec];
    assign vec_w[1] = 16'(ib.vec);
    assign fv_w[1] = 16'(ib.fail_vec);
    assign err_w[1] = 8'(ib.err_count);
    assign busy_w[1] = ib.busy;
    assign done_w[1] = ib.done;
    assign pass_w[1] = ib.pass;
    assign fail_w[1] = ib.fail;
    assign fg_w[1] = ib.fail_got;
    assign ic.start = start_r[2];
    assign ic.dut_y = tab_r[2][ic.vec];
    assign vec_w[2] = 16'(ic.vec);
    assign fv_w[2] = 16'(ic.fail_vec);
    assign err_w[2] = 8'(ic.err_count);
    assign busy_w[2] = ic.busy;
    assign done_w[2] = ic.done;
    assign pass_w[2] = ic.pass;
    assign fail_w[2] = ic.fail;
    assign fg_w[2] = ic.fail_got;

    function automatic logic expv(input int i, input int k);
        int top;
        top = (1 << nn[i]) - 1;
        case (fn[i])
            0: return k == 0;
            1: return k != 0;
            2: return k != top;
            default: return k == top;
        endcase
    endfunction

    function automatic logic [15:0] good(input int i);
        logic [15:0] t;
        t = '0;
        for (int k = 0; k < (1 << nn[i]); k++) t[k] = expv(i, k);
        return t;
    endfunction

    // Whole-sweep outcome from the table of gate outputs, one vector at a time
    function automatic void model(input int i, input logic [15:0] tab, output int err, output logic [15:0] fv,
                                  output logic fg, output int cyc, output logic [15:0] lastv);
        logic y;
        err = 0; fv = '0; fg = 1'b0; cyc = 0; lastv = '0;
        for (int k = 0; k < (1 << nn[i]); k++) begin
            y = tab[k];
            cyc += st[i] + 1;
            lastv = 16'(k);
            if (y !== expv(i, k)) begin
                if (err == 0) begin fv = 16'(k); fg = y; end
                if (err < (1 << ew[i]) - 1) err++;
                if (sp[i] != 0) break;
            end
        end
    endfunction

    task automatic sweep(input int i, input int restart_at, output int cyc, output int bsy, output int badv);
        @(negedge clk) start_r[i] = 1'b1;
        @(negedge clk) start_r[i] = 1'b0;
        cyc = 0; bsy = 0; badv = 0;
        while (!done_w[i] && cyc < 400) begin
            if (busy_w[i]) bsy++;
            if (vec_w[i] != 16'(cyc / (st[i] + 1))) badv++;
            start_r[i] = cyc == restart_at;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start_r[i] = 1'b0;
    endtask

    task automatic test_reset;
        rst_ = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({vec_w[i], fv_w[i], err_w[i], busy_w[i], done_w[i], pass_w[i], fail_w[i], fg_w[i]} !== 45'd0) begin
                errors++;
                $display("FAIL reset[%0d] outputs got=%h want=0", i,
                         {vec_w[i], fv_w[i], err_w[i], busy_w[i], done_w[i], pass_w[i], fail_w[i], fg_w[i]});
            end
        end
        rst_ = 1'b1;
    endtask

    task automatic test_nor_pass;
        int cyc, bsy, badv;
        tab_r[0] = good(0);
        sweep(0, -1, cyc, bsy, badv);
        checks++; if (cyc != 16) begin errors++; $display("FAIL nor_pass cycles got=%0d want=16", cyc); end
        checks++; if (bsy != 16) begin errors++; $display("FAIL nor_pass busy_cycles got=%0d want=16", bsy); end
        checks++; if (badv != 0) begin errors++; $display("FAIL nor_pass vec_steps bad=%0d want=0", badv); end
        checks++; if ({done_w[0], pass_w[0], fail_w[0], err_w[0]} !== {3'b110, 8'd0}) begin
            errors++; $display("FAIL nor_pass done/pass/fail/err got=%b want=110/0", {done_w[0], pass_w[0], fail_w[0], err_w[0]});
        end
    endtask

    task automatic test_stuck_stop;
        int cyc, bsy, badv;
        tab_r[0] = good(0);
        tab_r[0][5] = 1'b1;
        sweep(0, -1, cyc, bsy, badv);
        checks++; if (cyc != 12) begin errors++; $display("FAIL stuck_stop cycles got=%0d want=12", cyc); end
        checks++; if (fv_w[0] !== 16'd5 || fg_w[0] !== 1'b1) begin
            errors++; $display("FAIL stuck_stop fail_vec/got got=%0d/%b want=5/1", fv_w[0], fg_w[0]);
        end
        checks++; if (err_w[0] !== 8'd1 || fail_w[0] !== 1'b1 || vec_w[0] !== 16'd5) begin
            errors++; $display("FAIL stuck_stop err/fail/vec got=%0d/%b/%0d want=1/1/5", err_w[0], fail_w[0], vec_w[0]);
        end
    endtask

    task automatic test_or_all_fail;
        int cyc, bsy, badv;
        tab_r[1] = 16'h0001;
        sweep(1, -1, cyc, bsy, badv);
        checks++; if (cyc != 16) begin errors++; $display("FAIL or_all_fail cycles got=%0d want=16", cyc); end
        checks++; if (err_w[1] !== 8'd8 || fail_w[1] !== 1'b1) begin
            errors++; $display("FAIL or_all_fail err/fail got=%0d/%b want=8/1", err_w[1], fail_w[1]);
        end
        checks++; if (fv_w[1] !== 16'd0 || fg_w[1] !== 1'b1 || vec_w[1] !== 16'd7) begin
            errors++; $display("FAIL or_all_fail fv/fg/vec got=%0d/%b/%0d want=0/1/7", fv_w[1], fg_w[1], vec_w[1]);
        end
    endtask

    task automatic test_x_input;
        int cyc, bsy, badv, e_err, e_cyc;
        logic [15:0] e_fv, e_last;
        logic e_fg;
        tab_r[1] = good(1);
        tab_r[1][2] = 1'bx;
        model(1, tab_r[1], e_err, e_fv, e_fg, e_cyc, e_last);
        sweep(1, -1, cyc, bsy, badv);
        checks++; if (err_w[1] !== 8'd1 || fail_w[1] !== 1'b1) begin
            errors++; $display("FAIL x_input err/fail got=%0d/%b want=1/1", err_w[1], fail_w[1]);
        end
        checks++; if (fv_w[1] !== 16'd2 || fg_w[1] !== e_fg) begin
            errors++; $display("FAIL x_input fv/fg got=%0d/%b want=2/%b", fv_w[1], fg_w[1], e_fg);
        end
    endtask

    task automatic test_mid_reset;
        int cyc, bsy, badv, n;
        tab_r[0] = good(0);
        @(negedge clk) start_r[0] = 1'b1;
        @(negedge clk) start_r[0] = 1'b0;
        n = 0;
        while (vec_w[0] != 16'd4 && n < 100) begin @(negedge clk); n++; end
        checks++; if (vec_w[0] != 16'd4) begin errors++; $display("FAIL mid_reset reach_vec4 got=%0d want=4", vec_w[0]); end
        rst_ = 1'b0;
        @(negedge clk) rst_ = 1'b1;
        checks++;
        if ({vec_w[0], fv_w[0], err_w[0], busy_w[0], done_w[0], pass_w[0], fail_w[0], fg_w[0]} !== 45'd0) begin
            errors++; $display("FAIL mid_reset outputs got=%h want=0",
                               {vec_w[0], fv_w[0], err_w[0], busy_w[0], done_w[0], pass_w[0], fail_w[0], fg_w[0]});
        end
        sweep(0, -1, cyc, bsy, badv);
        checks++; if (pass_w[0] !== 1'b1 || cyc != 16) begin
            errors++; $display("FAIL mid_reset resweep pass/cycles got=%b/%0d want=1/16", pass_w[0], cyc);
        end
    endtask

    task automatic test_restart;
        int cyc, bsy, badv, n;
        tab_r[0] = good(0);
        sweep(0, 5, cyc, bsy, badv);
        checks++; if (cyc != 16 || badv != 0 || pass_w[0] !== 1'b1) begin
            errors++; $display("FAIL restart_in_run cycles/badvec/pass got=%0d/%0d/%b want=16/0/1", cyc, badv, pass_w[0]);
        end
        tab_r[1] = 16'h0001;
        sweep(1, -1, cyc, bsy, badv);
        @(negedge clk) start_r[1] = 1'b1;
        @(negedge clk) start_r[1] = 1'b0;
        checks++; if ({done_w[1], busy_w[1], vec_w[1], err_w[1], fail_w[1]} !== {2'b01, 16'd0, 8'd0, 1'b0}) begin
            errors++; $display("FAIL restart_in_done done/busy/vec/err/fail got=%h want=%h",
                               {done_w[1], busy_w[1], vec_w[1], err_w[1], fail_w[1]}, {2'b01, 16'd0, 8'd0, 1'b0});
        end
        n = 0;
        while (!done_w[1] && n < 100) begin @(negedge clk); n++; end
        checks++; if (n != 16 || err_w[1] !== 8'd8) begin
            errors++; $display("FAIL restart_in_done cycles/err got=%0d/%0d want=16/8", n, err_w[1]);
        end
    endtask

    task automatic test_and_sat;
        int cyc, bsy, badv;
        tab_r[2] = 16'h0001;
        sweep(2, -1, cyc, bsy, badv);
        checks++; if (cyc != 16 || badv != 0) begin
            errors++; $display("FAIL and_nor cycles/badvec got=%0d/%0d want=16/0", cyc, badv);
        end
        checks++; if (err_w[2] !== 8'd2 || fv_w[2] !== 16'd0 || fg_w[2] !== 1'b1 || vec_w[2] !== 16'd15) begin
            errors++; $display("FAIL and_nor err/fv/fg/vec got=%0d/%0d/%b/%0d want=2/0/1/15", err_w[2], fv_w[2], fg_w[2], vec_w[2]);
        end
        tab_r[2] = ~good(2);
        sweep(2, -1, cyc, bsy, badv);
        checks++; if (err_w[2] !== 8'd3 || fail_w[2] !== 1'b1) begin
            errors++; $display("FAIL and_saturate err/fail got=%0d/%b want=3/1", err_w[2], fail_w[2]);
        end
    endtask

    task automatic test_random;
        int i, cyc, bsy, badv, e_err, e_cyc;
        logic [15:0] m, e_fv, e_last;
        logic e_fg;
        for (int r = 0; r < 12; r++) begin
            i = $urandom_range(0, 2);
            m = 16'($urandom);
            if (r % 3 == 0) m = '0;
            else if (r % 3 == 1) m = m & 16'($urandom) & 16'($urandom);
            tab_r[i] = good(i) ^ (m & 16'((1 << (1 << nn[i])) - 1));
            model(i, tab_r[i], e_err, e_fv, e_fg, e_cyc, e_last);
            sweep(i, -1, cyc, bsy, badv);
            checks++; if (cyc != e_cyc || bsy != e_cyc) begin
                errors++; $display("FAIL random[%0d] cycles/busy got=%0d/%0d want=%0d", r, cyc, bsy, e_cyc);
            end
            checks++; if (badv != 0) begin errors++; $display("FAIL random[%0d] vec_steps bad=%0d want=0", r, badv); end
            checks++; if (err_w[i] !== 8'(e_err)) begin
                errors++; $display("FAIL random[%0d] err_count got=%0d want=%0d", r, err_w[i], e_err);
            end
            checks++; if (fv_w[i] !== e_fv || fg_w[i] !== e_fg) begin
                errors++; $display("FAIL random[%0d] fail_vec/got got=%0d/%b want=%0d/%b", r, fv_w[i], fg_w[i], e_fv, e_fg);
            end
            checks++; if (vec_w[i] !== e_last) begin
                errors++; $display("FAIL random[%0d] final_vec got=%0d want=%0d", r, vec_w[i], e_last);
            end
            checks++; if ({done_w[i], busy_w[i], pass_w[i], fail_w[i]} !== {2'b10, e_err == 0, e_err != 0}) begin
                errors++; $display("FAIL random[%0d] done/busy/pass/fail got=%b want=%b", r,
                                   {done_w[i], busy_w[i], pass_w[i], fail_w[i]}, {2'b10, e_err == 0, e_err != 0});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin start_r[i] = 1'b0; tab_r[i] = '0; end
        test_reset;
        test_nor_pass;
        test_stuck_stop;
        test_or_all_fail;
        test_x_input;
        test_mid_reset;
        test_restart;
        test_and_sat;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
